hdmi_line_doubler: RTL
======================

Name: hdmi_line_doubler

Overview:
- Upstream pixel source for the HDMI output stage.
- Captures one VDP scanline at a time into ping-pong line RAMs.
- Replays each captured line twice, indexed by the HDMI raster counters cx/cy, and returns registered 24-bit rgb.
- Centres the source line horizontally and fills the remaining active area with a border colour.

Parameters:
- SRC_WIDTH, 512: pixels per source line. Must be <= 720.
- H_OFFSET, 104: first HDMI cx that shows source pixel 0.
- ADDR_W, 9: line RAM address width. Requires 2^ADDR_W >= SRC_WIDTH.

Ports:
- clk_pixel  in  1  pixel clock. Only clock in the block.
- reset  in  1  asynchronous, active-high reset.
- pal_mode  in  1  1 = 720x576 raster (VIC 17), 0 = 720x480 raster (VIC 2).
- wr_line_start  in  1  pulse: next wr_en pixel is pixel 0 of a new source line.
- wr_en  in  1  qualifies wr_data.
- wr_data  in  24  source pixel RGB888.
- border_rgb  in  24  colour shown outside the source window.
- cx  in  10  HDMI raster x.
- cy  in  10  HDMI raster y.
- rgb  out  24  pixel for (cx,cy), 2 cycles late.
- overflow  out  1  sticky: a line had more than SRC_WIDTH pixels.
- underrun  out  1  sticky: the display bank was re-latched with no new completed line.

Behaviour:
- Reset (async assert, sync release): rgb=0, overflow=0, underrun=0, wr_bank=0, wr_ptr=0, completed_valid=0, disp_valid=0, disp_bank=0.
- Write side:
  - wr_en writes wr_data to bank wr_bank at address wr_ptr, then wr_ptr increments.
  - When wr_ptr==SRC_WIDTH, further wr_en is dropped and overflow is set. wr_ptr saturates; no wrap.
  - wr_line_start with wr_ptr>0:
    - completed_bank <= wr_bank and completed_valid <= 1.
    - wr_bank toggles and wr_ptr <= 0.
  - wr_line_start with wr_ptr==0: no bank swap, no completion (empty line is ignored).
  - wr_line_start and wr_en in the same cycle: the line start applies first, so the pixel is written at address 0 of the new bank. wr_ptr becomes 1.
- Read side, display latch:
  - Fires at cx==0 with cy[0]==0. Latches disp_bank <= completed_bank and disp_valid <= completed_valid.
  - Each source line is therefore shown on two consecutive HDMI lines.
  - If the latch fires while completed_valid==1 but no new completion has occurred since the previous latch:
    - underrun is set;
    - the old line repeats, because the latch reloads the same completed_bank.
  - If a completion and a latch fire in the same cycle, the latch sees the pre-update completed_bank, i.e. the older line.
- Read side, region decode (stage 0, combinational from cx/cy):
  - active = cx<720 and cy<(pal_mode?576:480).
  - window = active and H_OFFSET<=cx<H_OFFSET+SRC_WIDTH and disp_valid.
  - Read address = cx-H_OFFSET, truncated to ADDR_W.
- Read side, pipeline:
  - Stage 1: RAM read of disp_bank; region flags registered.
  - Stage 2: rgb <= window ? ram_q : (active ? border_rgb : 24'h0).
  - Latency is exactly 2 clk_pixel cycles from cx/cy to rgb.
- Read/write collision:
  - Reads never target wr_bank while disp_bank!=wr_bank.
  - When disp_bank==wr_bank (writer lapped), read-before-write data is returned. This is not an error.
- Sticky flags clear only on reset.
- Line RAM: 2 x 2^ADDR_W x 24 bits, simple dual-port, registered read.
- pal_mode may change at any time; it takes effect on the next cycle's region decode.

Test Plan:
1. Reset mid-line:
   - Stimulus: write 100 pixels, assert reset, release.
   - Response: all outputs 0. The first latch gives border-only output (disp_valid=0), since no line completed after reset.
2. Single line doubled:
   - Stimulus: write pixel i = {8'd0, i[15:0]} for i=0..511, then pulse wr_line_start. Sweep cx 0..799 for cy=0 and cy=1.
   - Response:
     - cx=104 gives 24'h000000, two cycles later;
     - cx=615 gives 24'h0001FF;
     - cx=103 and cx=616 give border_rgb;
     - cx=720 gives 0;
     - cy=1 output is identical to cy=0.
3. Overflow:
   - Stimulus: 520 wr_en pixels, then wr_line_start.
   - Response: overflow=1. Pixels 512..519 are discarded; cx=615 still shows pixel 511.
4. Underrun:
   - Stimulus: complete one line, then run latches at cy=0 and cy=2 with no new line.
   - Response: underrun=1 after the cy=2 latch; the same pixels are repeated.
5. PAL/NTSC region:
   - Stimulus: cy=500 with pal_mode=0, then pal_mode=1.
   - Response: rgb=0 with pal_mode=0; border/pixel data with pal_mode=1.
6. Empty line and simultaneous start+write:
   - Stimulus: two wr_line_start back-to-back, then wr_line_start and wr_en (data 24'hABCDEF) together.
   - Response: only one bank swap occurs. Address 0 of the new bank holds 24'hABCDEF.

Source files
------------

// File: rtl/hdmi_line_doubler.sv
// hdmi_line_doubler: captures one source scanline at a time into a pair of
// ping-pong line RAMs and replays each completed line on two consecutive HDMI
// lines. The source line is centred horizontally at H_OFFSET and the rest of
// the active raster is filled with a border colour. The pixel output follows
// cx/cy by exactly two clk_pixel cycles.
module hdmi_line_doubler #(
   parameter int SRC_WIDTH = 512,   // pixels per source line, at most 720
   parameter int H_OFFSET  = 104,   // first HDMI cx showing source pixel 0
   parameter int ADDR_W    = 9      // line RAM address width, 2^ADDR_W >= SRC_WIDTH
) (
   input  logic        clk_pixel,
   input  logic        reset,
   input  logic        pal_mode,
   input  logic        wr_line_start,
   input  logic        wr_en,
   input  logic [23:0] wr_data,
   input  logic [23:0] border_rgb,
   input  logic [9:0]  cx,
   input  logic [9:0]  cy,
   output logic [23:0] rgb,
   output logic        overflow,
   output logic        underrun
);

   // The write pointer must be able to hold SRC_WIDTH itself, which is the
   // saturated "line full" value, so it can be one bit wider than ADDR_W.
   localparam int PTR_W = $clog2(SRC_WIDTH + 1);
   localparam int DEPTH = 1 << ADDR_W;

   localparam logic [PTR_W-1:0] PTR_FULL = PTR_W'(SRC_WIDTH);
   localparam logic [10:0]      WIN_LO   = 11'(H_OFFSET);
   localparam logic [10:0]      WIN_HI   = 11'(H_OFFSET + SRC_WIDTH);
   localparam logic [9:0]       H_ACTIVE = 10'd720;
   localparam logic [9:0]       V_PAL    = 10'd576;
   localparam logic [9:0]       V_NTSC   = 10'd480;

   // Write-side state
   logic              wr_bank;
   logic [PTR_W-1:0]  wr_ptr;

   // Hand-over from writer to reader
   logic              completed_bank;
   logic              completed_valid;
   logic              completed_fresh;

   // Display-side state
   logic              disp_bank;
   logic              disp_valid;

   // Write-side combinational decode
   logic              line_swap;
   logic [PTR_W-1:0]  wr_ptr_eff;
   logic              wr_bank_eff;
   logic              wr_accept;
   logic              wr_drop;
   logic [ADDR_W-1:0] wr_addr;

   // Read-side stage 0 decode
   logic              disp_latch;
   logic              active;
   logic              in_span;
   logic              window;
   logic [ADDR_W-1:0] rd_addr;

   // Read-side pipeline registers
   logic [23:0]       ram_q;
   logic              window_q;
   logic              active_q;

   // Two banks of DEPTH pixels, addressed as {bank, pixel}
   logic [23:0]       line_ram [0:2*DEPTH-1];

   // ------------------------------------------------------------------------
   // Write side
   // ------------------------------------------------------------------------

   // A line start only swaps banks when the current line holds at least one
   // pixel; an empty line is ignored. The swap is applied before any pixel
   // arriving in the same cycle, so that pixel lands at address 0 of the new
   // bank.
   always_comb begin
      line_swap   = wr_line_start && (wr_ptr != '0);
      wr_ptr_eff  = line_swap ? '0 : wr_ptr;
      wr_bank_eff = line_swap ? ~wr_bank : wr_bank;
      wr_accept   = wr_en && (wr_ptr_eff != PTR_FULL);
      wr_drop     = wr_en && (wr_ptr_eff == PTR_FULL);
      wr_addr     = ADDR_W'(wr_ptr_eff);
   end

   // Writer bank/pointer tracking; the pointer saturates at SRC_WIDTH and any
   // pixel beyond that is dropped and flagged as a sticky overflow.
   always_ff @(posedge clk_pixel or posedge reset) begin
      if (reset) begin
         wr_bank  <= 1'b0;
         wr_ptr   <= '0;
         overflow <= 1'b0;
      end else begin
         if (line_swap) begin
            wr_bank <= ~wr_bank;
         end
         if (wr_accept) begin
            wr_ptr <= wr_ptr_eff + PTR_W'(1);
         end else if (line_swap) begin
            wr_ptr <= '0;
         end
         if (wr_drop) begin
            overflow <= 1'b1;
         end
      end
   end

   // Publish the bank that just finished. completed_fresh remembers whether a
   // new line arrived since the last display latch; a completion in the same
   // cycle as a latch stays fresh for the following latch.
   always_ff @(posedge clk_pixel or posedge reset) begin
      if (reset) begin
         completed_bank  <= 1'b0;
         completed_valid <= 1'b0;
         completed_fresh <= 1'b0;
      end else begin
         if (line_swap) begin
            completed_bank  <= wr_bank;
            completed_valid <= 1'b1;
         end
         if (line_swap) begin
            completed_fresh <= 1'b1;
         end else if (disp_latch) begin
            completed_fresh <= 1'b0;
         end
      end
   end

   // Line RAM write port; the RAM has no reset so it maps onto block memory.
   always_ff @(posedge clk_pixel) begin
      if (wr_accept) begin
         line_ram[{wr_bank_eff, wr_addr}] <= wr_data;
      end
   end

   // ------------------------------------------------------------------------
   // Read side
   // ------------------------------------------------------------------------

   // Stage 0: the display latch fires at the start of every even HDMI line,
   // and the region flags and RAM address come straight from the raster
   // counters. pal_mode is used directly so a change shows up on the very
   // next decode.
   always_comb begin
      disp_latch = (cx == '0) && !cy[0];
      active     = (cx < H_ACTIVE) && (cy < (pal_mode ? V_PAL : V_NTSC));
      in_span    = ({1'b0, cx} >= WIN_LO) && ({1'b0, cx} < WIN_HI);
      window     = active && in_span && disp_valid;
      rd_addr    = ADDR_W'(cx - 10'(H_OFFSET));
   end

   // Display bank latch. Re-latching a valid line that has not been replaced
   // since the previous latch means the writer fell behind, so the old line
   // repeats and underrun is flagged.
   always_ff @(posedge clk_pixel or posedge reset) begin
      if (reset) begin
         disp_bank  <= 1'b0;
         disp_valid <= 1'b0;
         underrun   <= 1'b0;
      end else if (disp_latch) begin
         disp_bank  <= completed_bank;
         disp_valid <= completed_valid;
         if (completed_valid && !completed_fresh) begin
            underrun <= 1'b1;
         end
      end
   end

   // Stage 1 RAM read port; when the writer has lapped onto the display bank
   // a same-address read returns the old contents.
   always_ff @(posedge clk_pixel) begin
      ram_q <= line_ram[{disp_bank, rd_addr}];
   end

   // Stage 1 region flags, kept in step with the RAM read.
   always_ff @(posedge clk_pixel or posedge reset) begin
      if (reset) begin
         window_q <= 1'b0;
         active_q <= 1'b0;
      end else begin
         window_q <= window;
         active_q <= active;
      end
   end

   // Stage 2 output mux: source pixel inside the window, border elsewhere in
   // the active area, black in blanking.
   always_ff @(posedge clk_pixel or posedge reset) begin
      if (reset) begin
         rgb <= 24'h0;
      end else if (window_q) begin
         rgb <= ram_q;
      end else if (active_q) begin
         rgb <= border_rgb;
      end else begin
         rgb <= 24'h0;
      end
   end

endmodule
